// File: rtl/overlay_line_fetcher.sv
// overlay_line_fetcher: schedules fixed-length Avalon-MM read bursts that fetch one overlay line per request.
module overlay_line_fetcher #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_BYTES     = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h3000_0000,
    parameter int                    LINE_STRIDE    = 5120,
    parameter int                    BEATS_PER_LINE = 640,
    parameter int                    BURST_LEN      = 16,
    parameter int                    NUM_LINES      = 720,
    parameter int                    CNT_WIDTH      = 11
) (
    input  logic                  clock,
    input  logic                  masterReset_n,
    input  logic                  enable,
    input  logic                  frameStart,
    input  logic                  lineRequest,
    input  logic [CNT_WIDTH-1:0]  fifoFree,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic                  avm_read,
    output logic [7:0]            avm_burstcount,
    input  logic                  avm_waitrequest,
    input  logic                  avm_readdatavalid,
    output logic                  busy,
    output logic                  lineDone,
    output logic                  overrunErr
);
    localparam int BURSTS = BEATS_PER_LINE / BURST_LEN;
    localparam int BL_W   = $clog2(BURSTS + 1);
    localparam int IDX_W  = $clog2(NUM_LINES + 1);
    localparam logic [BL_W-1:0]       BURSTS_INIT = BL_W'(BURSTS);
    localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_LINES - 1);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * DATA_BYTES);
    localparam logic [ADDR_WIDTH-1:0] STRIDE      = ADDR_WIDTH'(LINE_STRIDE);
    localparam logic [CNT_WIDTH-1:0]  BURST_CNT   = CNT_WIDTH'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, CHECK, ISSUE, DRAIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic [ADDR_WIDTH-1:0] burst_addr;
    logic [IDX_W-1:0]      line_idx;
    logic [BL_W-1:0]       bursts_left;
    logic [CNT_WIDTH-1:0]  outstanding;
    logic                  pend_frame;
    logic                  space_ok;
    logic                  accept;
    logic                  dec;
    logic [CNT_WIDTH-1:0]  out_inc;
    logic [CNT_WIDTH-1:0]  out_next;

    assign avm_burstcount = 8'(BURST_LEN);
    assign accept   = avm_read && !avm_waitrequest;
    // one extra bit keeps outstanding + BURST_LEN from wrapping in the space test
    assign space_ok = {1'b0, fifoFree} >= ({1'b0, outstanding} + {1'b0, BURST_CNT});
    // a beat returning with nothing outstanding is dropped so the count saturates at zero
    assign out_inc  = outstanding + (accept ? BURST_CNT : '0);
    assign dec      = avm_readdatavalid && (out_inc != '0);
    assign out_next = out_inc - {{(CNT_WIDTH-1){1'b0}}, dec};

    // line fetch state machine with registered bus and status outputs
    always_ff @(posedge clock or negedge masterReset_n) begin
        if (!masterReset_n) begin
            state       <= IDLE;
            line_addr   <= BASE_ADDR;
            burst_addr  <= '0;
            line_idx    <= '0;
            bursts_left <= '0;
            outstanding <= '0;
            pend_frame  <= 1'b0;
            avm_address <= '0;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            lineDone    <= 1'b0;
            overrunErr  <= 1'b0;
        end else begin
            outstanding <= out_next;
            lineDone    <= 1'b0;
            if (lineRequest && state != IDLE) overrunErr <= 1'b1;
            if (frameStart && state != IDLE) pend_frame <= 1'b1;
            case (state)
                IDLE: begin
                    if (frameStart) begin
                        line_addr <= BASE_ADDR;
                        line_idx  <= '0;
                    end
                    if (lineRequest && enable) begin
                        state       <= CHECK;
                        busy        <= 1'b1;
                        burst_addr  <= frameStart ? BASE_ADDR : line_addr;
                        bursts_left <= BURSTS_INIT;
                    end
                end
                CHECK: begin
                    if (space_ok) begin
                        state       <= ISSUE;
                        avm_read    <= 1'b1;
                        avm_address <= burst_addr;
                    end
                end
                ISSUE: begin
                    if (!avm_waitrequest) begin
                        avm_read    <= 1'b0;
                        burst_addr  <= burst_addr + BURST_BYTES;
                        bursts_left <= bursts_left - BL_W'(1);
                        state       <= (bursts_left > BL_W'(1)) ? CHECK : DRAIN;
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        lineDone <= 1'b1;
                        if (pend_frame || frameStart || line_idx == LAST_IDX) begin
                            line_addr  <= BASE_ADDR;
                            line_idx   <= '0;
                            pend_frame <= 1'b0;
                        end else begin
                            line_addr <= line_addr + STRIDE;
                            line_idx  <= line_idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_overlay_line_fetcher.sv
// tb_overlay_line_fetcher: randomized scoreboard bench with a behavioural DDR slave and line-address model.
module tb_overlay_line_fetcher;
    localparam int          NL     = 8;
    localparam int          NB     = 40;
    localparam int          BL     = 16;
    localparam int          STRIDE = 5120;
    localparam logic [31:0] BASE   = 32'h3000_0000;

    logic        clock = 0;
    logic        masterReset_n = 1;
    logic        enable = 0;
    logic        frameStart = 0;
    logic        lineRequest = 0;
    logic [10:0] fifoFree = 11'd1024;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [7:0]  avm_burstcount;
    logic        avm_waitrequest = 0;
    logic        avm_readdatavalid = 0;
    logic        busy;
    logic        lineDone;
    logic        overrunErr;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr[$];
    int          done_cnt = 0;
    int          line_acc = 0;
    int          tb_out = 0;
    bit          rdv_en = 1;
    bit          spur_req = 0;
    int          wait_pct = 0;
    int          stall_burst = -1;
    int          stall_left = 0;
    int          idx = 0;
    bit          pend = 0;

    always #5 clock = ~clock;

    overlay_line_fetcher #(.NUM_LINES(NL)) dut (
        .clock(clock), .masterReset_n(masterReset_n), .enable(enable), .frameStart(frameStart),
        .lineRequest(lineRequest), .fifoFree(fifoFree), .avm_address(avm_address), .avm_read(avm_read),
        .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid), .busy(busy), .lineDone(lineDone), .overrunErr(overrunErr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_line(input bit fs);
        @(negedge clock);
        if (fs) idx = 0;
        for (int b = 0; b < NB; b++) exp_addr.push_back(BASE + idx * STRIDE + b * BL * 8);
        line_acc = 0;
        lineRequest = 1;
        frameStart = fs;
        @(negedge clock);
        lineRequest = 0;
        frameStart = 0;
    endtask

    task automatic finish_line();
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check("line_done_seen", done_cnt != start, 1);
        if (done_cnt == start) exp_addr.delete();
        if (pend || idx == NL - 1) begin
            idx = 0;
            pend = 0;
        end else idx++;
    endtask

    task automatic wait_acc(input int n);
        int k;
        k = 0;
        while (line_acc < n && k < 2000) begin
            @(negedge clock);
            k++;
        end
        check("burst_count_reached", line_acc >= n, 1);
    endtask

    task automatic wait_read();
        int k;
        k = 0;
        while (!avm_read && k < 500) begin
            @(negedge clock);
            k++;
        end
        check("read_seen", avm_read, 1);
    endtask

    // DDR slave and monitor: drives waitrequest/readdatavalid, checks every accepted burst and lineDone
    initial begin
        bit          prev_stall;
        bit          prev_acc;
        bit          prev_done;
        bit          acc;
        logic [31:0] prev_addr;
        prev_stall = 0;
        prev_acc = 0;
        prev_done = 0;
        prev_addr = '0;
        forever begin
            @(negedge clock);
            if (!masterReset_n) begin
                tb_out = 0;
                prev_stall = 0;
                prev_acc = 0;
                prev_done = 0;
                avm_waitrequest = 0;
                avm_readdatavalid = 0;
                continue;
            end
            if (prev_stall) check("stall_hold", {avm_read, avm_address}, {1'b1, prev_addr});
            if (prev_acc) check("read_drop", avm_read, 0);
            if (lineDone) begin
                check("done_pulse_width", prev_done, 0);
                check("done_outstanding", tb_out, 0);
                check("done_bursts_left", exp_addr.size(), 0);
                done_cnt++;
            end
            prev_done = lineDone;
            if (avm_read && line_acc == stall_burst && stall_left > 0) begin
                avm_waitrequest = 1;
                stall_left--;
            end else avm_waitrequest = ($urandom_range(99) < wait_pct);
            if (spur_req && tb_out == 0) begin
                avm_readdatavalid = 1;
                spur_req = 0;
            end else avm_readdatavalid = rdv_en && tb_out > 0 && ($urandom_range(99) < 75);
            acc = avm_read && !avm_waitrequest;
            if (acc) begin
                check("burstcount", avm_burstcount, BL);
                check("fifo_space", fifoFree >= tb_out + BL, 1);
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_burst: got addr %0h expected no burst", avm_address);
                end else check("burst_addr", avm_address, exp_addr.pop_front());
                line_acc++;
            end
            tb_out += acc ? BL : 0;
            if (avm_readdatavalid && tb_out > 0) tb_out--;
            prev_stall = avm_read && avm_waitrequest;
            prev_addr = avm_address;
            prev_acc = acc;
        end
    end

    // stimulus and line-address model
    initial begin
        #2 masterReset_n = 0;
        #1;
        check("rst_read", avm_read, 0);
        check("rst_addr", avm_address, 0);
        check("rst_busy", busy, 0);
        check("rst_done", lineDone, 0);
        check("rst_overrun", overrunErr, 0);
        check("rst_burstcount", avm_burstcount, BL);
        repeat (3) @(negedge clock);
        masterReset_n = 1;
        enable = 1;
        start_line(0);
        check("lat_cycle1_read", avm_read, 0);
        check("lat_cycle1_busy", busy, 1);
        @(negedge clock);
        check("lat_cycle2_read", avm_read, 1);
        check("lat_cycle2_addr", avm_address, BASE);
        finish_line();
        check("idle_after_line", busy, 0);
        wait_pct = 25;
        fifoFree = 20;
        rdv_en = 0;
        start_line(0);
        wait_acc(1);
        repeat (12) @(negedge clock);
        check("gated_bursts", line_acc, 1);
        check("gated_read", avm_read, 0);
        fifoFree = 32;
        wait_acc(2);
        rdv_en = 1;
        finish_line();
        fifoFree = 1024;
        stall_burst = 2;
        stall_left = 5;
        start_line(0);
        finish_line();
        check("stall_applied", stall_left, 0);
        stall_burst = -1;
        for (int k = 0; k < 12; k++) begin
            fifoFree = 11'($urandom_range(16, 300));
            if (k == 6) begin
                spur_req = 1;
                repeat (4) @(negedge clock);
                check("spurious_idle", busy, 0);
            end
            start_line(k == 10);
            if (k == 9) begin
                repeat (20) @(negedge clock);
                frameStart = 1;
                @(negedge clock);
                frameStart = 0;
                pend = 1;
            end
            finish_line();
        end
        fifoFree = 1024;
        enable = 0;
        @(negedge clock);
        lineRequest = 1;
        @(negedge clock);
        lineRequest = 0;
        repeat (10) @(negedge clock);
        check("disabled_busy", busy, 0);
        check("disabled_overrun", overrunErr, 0);
        enable = 1;
        start_line(0);
        repeat (20) @(negedge clock);
        enable = 0;
        finish_line();
        enable = 1;
        start_line(0);
        wait_read();
        lineRequest = 1;
        @(negedge clock);
        lineRequest = 0;
        check("overrun_set", overrunErr, 1);
        finish_line();
        repeat (5) @(negedge clock);
        check("overrun_sticky", overrunErr, 1);
        start_line(0);
        wait_acc(3);
        wait_read();
        masterReset_n = 0;
        #1;
        check("midrst_outputs", {avm_read, busy, lineDone, overrunErr}, 0);
        check("midrst_addr", avm_address, 0);
        exp_addr.delete();
        idx = 0;
        pend = 0;
        repeat (3) @(negedge clock);
        masterReset_n = 1;
        start_line(0);
        finish_line();
        check("post_rst_overrun", overrunErr, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // hard stop in case the run never reaches its summary
    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end
endmodule
